// File: rtl/axi_lite_master.sv
// Purpose: turns single-word CPU memory requests into single-beat AXI4 read/write transactions.
// Latency: zero-wait slave gives done_o three cycles after the accepted req_i; one transaction in flight.
// Backpressure: holds AR/AW/W valid until ready is seen, holds R/B ready while waiting; req_i ignored while busy.
module axi_lite_master #(
    parameter logic [3:0] MASTER_ID = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic [3:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [3:0]  rid_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic [3:0]  awlen_o,
    output logic [2:0]  awsize_o,
    output logic [1:0]  awburst_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic [3:0]  bid_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

    logic [2:0]  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done;
    logic        w_done;
    logic        aw_hs;
    logic        w_hs;

    // Single-beat transfers only, so the last-beat marker carries no information.
    logic unused_rlast;
    assign unused_rlast = rlast_i;

    // Fixed single-beat, full-word, INCR attributes.
    assign arid_o    = MASTER_ID;
    assign awid_o    = MASTER_ID;
    assign arlen_o   = 4'd0;
    assign awlen_o   = 4'd0;
    assign arsize_o  = 3'b010;
    assign awsize_o  = 3'b010;
    assign arburst_o = BURST_INCR;
    assign awburst_o = BURST_INCR;
    assign wlast_o   = 1'b1;

    // Channel payloads come straight from the captured request so they cannot move mid-handshake.
    assign araddr_o  = addr_q;
    assign awaddr_o  = addr_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;

    assign busy_o    = (state != S_IDLE);
    assign arvalid_o = (state == S_AR);
    assign rready_o  = (state == S_R);
    assign awvalid_o = (state == S_WR) && !aw_done;
    assign wvalid_o  = (state == S_WR) && !w_done;
    assign bready_o  = (state == S_B);

    assign aw_hs = awvalid_o && awready_i;
    assign w_hs  = wvalid_o && wready_i;

    // Transaction sequencer plus registered completion/error pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_o <= 32'd0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_i) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        wstrb_q <= wstrb_i;
                        state   <= we_i ? S_WR : S_AR;
                    end
                end
                S_AR: begin
                    if (arready_i) begin
                        state <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid_i) begin
                        rdata_o <= rdata_i;
                        done_o  <= 1'b1;
                        err_o   <= (rresp_i != RESP_OKAY) || (rid_i != MASTER_ID);
                        state   <= S_IDLE;
                    end
                end
                S_WR: begin
                    // AW and W complete independently; leave once both are in, counting this cycle.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= S_B;
                    end else begin
                        if (aw_hs) begin
                            aw_done <= 1'b1;
                        end
                        if (w_hs) begin
                            w_done <= 1'b1;
                        end
                    end
                end
                S_B: begin
                    if (bvalid_i) begin
                        done_o <= 1'b1;
                        err_o  <= (bresp_i != RESP_OKAY) || (bid_i != MASTER_ID);
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Purpose: drives axi_lite_master against a behavioural AXI slave and a word-memory reference model.
// Latency: checks done_o at the exact cycle implied by the slave delays chosen for each transaction.
// Backpressure: slave inserts programmable ready/valid delays; valid/address stability checked every wait cycle.
module tb_axi_lite_master;

    localparam logic [3:0] MID = 4'h3;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        err_o;
    logic        busy_o;
    logic [3:0]  arid_o;
    logic [31:0] araddr_o;
    logic [3:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [3:0]  rid_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rlast_i;
    logic        rvalid_i;
    logic        rready_o;
    logic [3:0]  awid_o;
    logic [31:0] awaddr_o;
    logic [3:0]  awlen_o;
    logic [2:0]  awsize_o;
    logic [1:0]  awburst_o;
    logic        awvalid_o;
    logic        awready_i;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        wlast_o;
    logic        wvalid_o;
    logic        wready_i;
    logic [3:0]  bid_i;
    logic [1:0]  bresp_i;
    logic        bvalid_i;
    logic        bready_o;

    int checks = 0;
    int errors = 0;

    // Slave-side storage (written from what the DUT actually drives) and the expected image.
    logic [31:0] slv_mem [16];
    logic [31:0] exp_mem [16];

    axi_lite_master #(.MASTER_ID(MID)) dut (
        .clk(clk), .rst(rst),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
        .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
        .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
        .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit unmapped(input logic [31:0] a);
        return a[31:28] == 4'hF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Starts at a negedge with the DUT idle; returns at the negedge where done_o must be visible.
    task automatic do_read(input logic [31:0] a, input int ar_d, input int r_d, input int inj, input bit poke);
        logic [31:0] cap;
        logic [31:0] exp_d;
        bit          exp_e;
        exp_d = unmapped(a) ? 32'd0 : exp_mem[a[5:2]];
        exp_e = unmapped(a) || (inj != 0);
        req_i = 1'b1; we_i = 1'b0; addr_i = a; wdata_i = $urandom; wstrb_i = 4'($urandom);
        cap = 32'd0;
        for (int k = 0; k <= ar_d; k++) begin
            @(negedge clk);
            chk("rd_arvalid", {31'd0, arvalid_o}, 32'd1);
            chk("rd_araddr", araddr_o, a);
            chk("rd_busy", {31'd0, busy_o}, 32'd1);
            chk("rd_done_early", {31'd0, done_o}, 32'd0);
            if (poke && k < ar_d) begin
                req_i = 1'b1; we_i = 1'($urandom); addr_i = ~a;
            end else begin
                req_i = 1'b0;
            end
            arready_i = (k == ar_d);
            cap = araddr_o;
        end
        for (int k = 0; k <= r_d; k++) begin
            @(negedge clk);
            arready_i = 1'b0; req_i = 1'b0;
            chk("rd_arvalid_off", {31'd0, arvalid_o}, 32'd0);
            chk("rd_rready", {31'd0, rready_o}, 32'd1);
            chk("rd_err_idle", {31'd0, err_o}, 32'd0);
            rvalid_i = (k == r_d);
            if (k == r_d) begin
                rdata_i = unmapped(cap) ? 32'd0 : slv_mem[cap[5:2]];
                rresp_i = unmapped(cap) ? 2'b11 : (inj == 1 ? 2'b10 : 2'b00);
                rid_i   = (inj == 2) ? (MID ^ 4'h5) : MID;
            end else begin
                rdata_i = $urandom; rresp_i = 2'($urandom); rid_i = 4'($urandom);
            end
        end
        @(negedge clk);
        rvalid_i = 1'b0; rdata_i = $urandom;
        chk("rd_done", {31'd0, done_o}, 32'd1);
        chk("rd_err", {31'd0, err_o}, {31'd0, exp_e});
        chk("rd_rdata", rdata_o, exp_d);
        chk("rd_busy_end", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_d, input int w_d, input int b_d, input int inj);
        bit aw_seen, w_seen;
        int n;
        logic [31:0] cap_a, cap_d;
        logic [3:0]  cap_s;
        bit exp_e;
        exp_e = unmapped(a) || (inj != 0);
        if (!unmapped(a)) exp_mem[a[5:2]] = merge(exp_mem[a[5:2]], d, s);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; wstrb_i = s;
        aw_seen = 0; w_seen = 0; n = 0;
        cap_a = 32'd0; cap_d = 32'd0; cap_s = 4'd0;
        while (!(aw_seen && w_seen) && n < 40) begin
            @(negedge clk);
            req_i = 1'b0;
            chk("wr_awvalid", {31'd0, awvalid_o}, {31'd0, !aw_seen});
            chk("wr_wvalid", {31'd0, wvalid_o}, {31'd0, !w_seen});
            chk("wr_done_early", {31'd0, done_o}, 32'd0);
            if (!aw_seen) chk("wr_awaddr", awaddr_o, a);
            if (!w_seen) begin
                chk("wr_wdata", wdata_o, d);
                chk("wr_wstrb", {28'd0, wstrb_o}, {28'd0, s});
            end
            awready_i = (n >= aw_d);
            wready_i  = (n >= w_d);
            if (awready_i && awvalid_o) begin aw_seen = 1; cap_a = awaddr_o; end
            if (wready_i && wvalid_o) begin w_seen = 1; cap_d = wdata_o; cap_s = wstrb_o; end
            n++;
        end
        chk("wr_aw_w_timeout", {31'd0, aw_seen && w_seen}, 32'd1);
        if (!unmapped(cap_a)) slv_mem[cap_a[5:2]] = merge(slv_mem[cap_a[5:2]], cap_d, cap_s);
        for (int k = 0; k <= b_d; k++) begin
            @(negedge clk);
            awready_i = 1'b0; wready_i = 1'b0;
            chk("wr_bready", {31'd0, bready_o}, 32'd1);
            chk("wr_aw_w_off", {30'd0, awvalid_o, wvalid_o}, 32'd0);
            chk("wr_err_idle", {31'd0, err_o}, 32'd0);
            bvalid_i = (k == b_d);
            bresp_i  = unmapped(cap_a) ? 2'b11 : (inj == 1 ? 2'b10 : 2'b00);
            bid_i    = (inj == 2) ? (MID ^ 4'h9) : MID;
        end
        @(negedge clk);
        bvalid_i = 1'b0;
        chk("wr_done", {31'd0, done_o}, 32'd1);
        chk("wr_err", {31'd0, err_o}, {31'd0, exp_e});
        chk("wr_busy_end", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_valids"}, {29'd0, arvalid_o, awvalid_o, wvalid_o}, 32'd0);
        chk({tag, "_readys"}, {30'd0, rready_o, bready_o}, 32'd0);
        chk({tag, "_done_err"}, {30'd0, done_o, err_o}, 32'd0);
        chk({tag, "_rdata"}, rdata_o, 32'd0);
        chk({tag, "_addr"}, araddr_o | awaddr_o, 32'd0);
        chk({tag, "_wdata"}, wdata_o, 32'd0);
        chk({tag, "_wstrb"}, {28'd0, wstrb_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int inj;
        rst = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0; wstrb_i = 4'd0;
        arready_i = 1'b0; rid_i = 4'd0; rdata_i = 32'd0; rresp_i = 2'd0; rlast_i = 1'b1; rvalid_i = 1'b0;
        awready_i = 1'b0; wready_i = 1'b0; bid_i = 4'd0; bresp_i = 2'd0; bvalid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = $urandom;
            exp_mem[i] = slv_mem[i];
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state and constant AXI attributes.
        chk_all_zero("reset");
        chk("const_ids", {24'd0, arid_o, awid_o}, {24'd0, MID, MID});
        chk("const_len", {24'd0, arlen_o, awlen_o}, 32'd0);
        chk("const_size", {26'd0, arsize_o, awsize_o}, {26'd0, 3'b010, 3'b010});
        chk("const_burst_last", {27'd0, arburst_o, awburst_o, wlast_o}, {27'd0, 2'b01, 2'b01, 1'b1});

        // Zero-wait read: arvalid at cycle 1, done at cycle 3.
        slv_mem[1] = 32'hDEADBEEF; exp_mem[1] = 32'hDEADBEEF;
        do_read(32'h0001_0004, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rdata_hold", rdata_o, 32'hDEADBEEF);
        chk("idle_no_done", {31'd0, done_o}, 32'd0);

        // Write with AW accepted two cycles before W.
        do_write(32'h0001_0008, 32'h1234_5678, 4'b0011, 0, 2, 0, 0);
        @(negedge clk);

        // Unmapped read: DECERR and zero data replace the old rdata_o.
        do_read(32'hF000_0100, 0, 1, 0, 0);
        @(negedge clk);

        // Address channel stall of five cycles with a stray request poked in.
        do_read(32'h2000_0000, 5, 0, 0, 1);
        @(negedge clk);

        // Back-to-back: read of the partially written word, then a write issued in the done cycle.
        do_read(32'h0001_0008, 0, 0, 0, 0);
        do_write(32'h0001_000C, 32'hCAFE_F00D, 4'b0000, 1, 0, 1, 0);
        do_read(32'h0001_000C, 1, 1, 0, 0);

        // Randomised mix against the memory model.
        for (int t = 0; t < 30; t++) begin
            a = $urandom;
            a[1:0] = 2'b00;
            if ($urandom_range(0, 5) == 0) a[31:28] = 4'hF;
            else if (a[31:28] == 4'hF) a[31:28] = 4'h0;
            inj = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), inj);
            else
                do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), inj, 1'($urandom));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // Reset while waiting in the B phase abandons the write.
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0001_0010; wdata_i = 32'hA5A5_5A5A; wstrb_i = 4'hF;
        @(negedge clk);
        req_i = 1'b0; awready_i = 1'b1; wready_i = 1'b1;
        @(negedge clk);
        awready_i = 1'b0; wready_i = 1'b0;
        chk("rst_in_b_bready", {31'd0, bready_o}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk_all_zero("midrst");
        bvalid_i = 1'b1; bresp_i = 2'b00; bid_i = MID;
        @(negedge clk);
        bvalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("midrst_no_done", {31'd0, done_o}, 32'd0);
            chk("midrst_idle", {31'd0, busy_o}, 32'd0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- AXI4 initiator that converts the CPU-side single-word memory request interface into single-beat AXI read and write transactions.
- One instance sits between each CPU memory port (IM, DM) and a master port of the AXI interconnect.
- It is the opposite end of the slaves (including the default slave) and must interoperate with DECERR responses from unmapped addresses.
- One outstanding transaction at a time, no bursts.

Parameters:
- MASTER_ID, 4'h0, value driven on arid_o/awid_o and expected on rid_i/bid_i.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active low
- req_i  input  1  core request strobe; sampled only in IDLE
- we_i  input  1  1 = write, 0 = read
- addr_i  input  32  byte address
- wdata_i  input  32  write data
- wstrb_i  input  4  byte enables; all-zero is still issued
- rdata_o  output  32  read data, valid when done_o = 1, held until next completion
- done_o  output  1  one-cycle completion pulse
- err_o  output  1  response error, valid with done_o
- busy_o  output  1  high whenever state != IDLE
- arid_o 4, araddr_o 32, arlen_o 4, arsize_o 3, arburst_o 2, arvalid_o 1 (outputs); arready_i 1 (input)
- rid_i 4, rdata_i 32, rresp_i 2, rlast_i 1, rvalid_i 1 (inputs); rready_o 1 (output)
- awid_o 4, awaddr_o 32, awlen_o 4, awsize_o 3, awburst_o 2, awvalid_o 1 (outputs); awready_i 1 (input)
- wdata_o 32, wstrb_o 4, wlast_o 1, wvalid_o 1 (outputs); wready_i 1 (input)
- bid_i 4, bresp_i 2, bvalid_i 1 (inputs); bready_o 1 (output)

Behaviour:
- Constant outputs:
  - arlen_o = awlen_o = 0.
  - arsize_o = awsize_o = 3'b010.
  - arburst_o = awburst_o = INCR.
  - wlast_o = 1.
  - arid_o = awid_o = MASTER_ID.
- Reset (rst = 0 at posedge):
  - State goes to IDLE.
  - All valid/ready outputs, done_o and err_o are 0.
  - rdata_o and the address/data registers are 0.
  - Reset mid-transaction abandons it; no done_o is produced.
- State machine: IDLE, AR, R, WR, B.
- IDLE:
  - If req_i = 1, capture addr_i, wdata_i, wstrb_i and we_i.
  - Next state is WR if we_i = 1, else AR.
- AR:
  - arvalid_o = 1, araddr_o = captured address.
  - On arready_i, go to R.
  - arvalid_o and araddr_o stay stable until the handshake.
- R:
  - rready_o = 1.
  - On rvalid_i, capture rdata_i into rdata_o.
  - Set err_o_next = (rresp_i != OKAY) | (rid_i != MASTER_ID).
  - Go to IDLE.
  - rlast_i is not checked.
- WR:
  - awvalid_o = !aw_done and wvalid_o = !w_done.
  - aw_done / w_done are set on their respective handshakes; both may complete in the same cycle.
  - Once both handshakes have occurred (including the current cycle), go to B and clear both flags.
  - Valids never drop before their ready is seen.
- B:
  - bready_o = 1.
  - On bvalid_i, set err_o_next = (bresp_i != OKAY) | (bid_i != MASTER_ID).
  - Go to IDLE.
- done_o and err_o are registered:
  - done_o pulses for exactly one cycle, the cycle after the R or B handshake, with state already IDLE.
  - err_o is 0 whenever done_o = 0.
- req_i asserted in that same IDLE cycle is accepted, so back-to-back requests are allowed.
- req_i is ignored while busy_o = 1.
- Read latency with zero-wait slave:
  - req at cycle 0, arvalid cycle 1, R handshake cycle 2, done_o cycle 3.
- Write latency with zero-wait slave:
  - req at cycle 0, aw/w handshake cycle 1, B handshake cycle 2, done_o cycle 3.
- A DECERR response sets err_o = 1.
- On a read error, rdata_o still takes rdata_i, i.e. 0 from the default slave.

Test Plan:
- Zero-wait read of 0x0001_0004 returning 0xDEADBEEF with OKAY -> arvalid_o at cycle 1, done_o pulse at cycle 3, rdata_o = 0xDEADBEEF, err_o = 0.
- Write 0x1234_5678 with wstrb 4'b0011; slave asserts awready 2 cycles before wready -> awvalid_o drops after its handshake, wvalid_o held until wready, single B phase, done_o = 1, err_o = 0.
- Read to an unmapped address; slave returns DECERR, rdata 0 -> done_o = 1, err_o = 1, rdata_o = 0.
- arready_i held low for 5 cycles while araddr_o = 0x2000_0000 -> arvalid_o and araddr_o stable all 5 cycles; a req_i pulse during this wait is ignored.
- Back-to-back read then write, with req_i high in the done_o cycle -> second transaction awvalid_o the next cycle, no idle bubble beyond one cycle.
- rst = 0 while in B waiting for bvalid -> next cycle all outputs 0 and state IDLE; a later bvalid_i produces no done_o.
